// File: rtl/ethernet_cfg_pkg.sv
// Shared types and widths for the Ethernet address configuration controller.
package ethernet_cfg_pkg;

  localparam int IP_W  = 32;
  localparam int MAC_W = 48;
  localparam int SW_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_UPDATE   = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/ethernet_switch_sync.sv
// Two-flop synchroniser for slow asynchronous board inputs (switches, straps).
module ethernet_switch_sync #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/ethernet_addr_cfg_ctrl.sv
// Debounces the DIP switches and offers a new IP/MAC/chip-ID set to the Ethernet
// core over valid/ready, committing it only on acceptance.
//   state    | meaning
//   IDLE     | committed set matches switches, or lock holds off a change
//   DEBOUNCE | candidate switch value must stay stable DEBOUNCE_CYCLES cycles
//   UPDATE   | pending set offered; held until cfg_ready_i accepts it
module ethernet_addr_cfg_ctrl
  import ethernet_cfg_pkg::*;
#(
  parameter logic [IP_W-1:0]  FPGA_IP_BASE    = {8'd192, 8'd168, 8'd42, 8'd240},
  parameter logic [MAC_W-1:0] FPGA_MAC_BASE   = 48'h080028_030405,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter int               NOC_CHIPID_SIZE = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [SW_W-1:0]            switches_i,
  input  logic                       cfg_lock_i,
  input  logic                       cfg_ready_i,
  output logic                       cfg_valid_o,
  output logic [IP_W-1:0]            cfg_pend_ip_o,
  output logic [MAC_W-1:0]           cfg_pend_mac_o,
  output logic [IP_W-1:0]            fpga_ip_addr_o,
  output logic [MAC_W-1:0]           fpga_mac_addr_o,
  output logic [NOC_CHIPID_SIZE-1:0] home_chipid_o,
  output logic [7:0]                 cfg_changes_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0] sw_sync;

  cfg_state_e       state_q, state_d;
  logic             first_cfg_q, first_cfg_d;
  logic [SW_W-1:0]  cand_q, cand_d;
  logic [SW_W-1:0]  sw_stable_q, sw_stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IP_W-1:0]  pend_ip_q, pend_ip_d;
  logic [MAC_W-1:0] pend_mac_q, pend_mac_d;
  logic [IP_W-1:0]  ip_q, ip_d;
  logic [MAC_W-1:0] mac_q, mac_d;
  logic [7:0]       changes_q, changes_d;

  ethernet_switch_sync #(.W(SW_W)) u_sw_sync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .async_i   (switches_i),
    .sync_o    (sw_sync)
  );

  always_comb begin
    state_d     = state_q;
    first_cfg_d = first_cfg_q;
    cand_d      = cand_q;
    sw_stable_d = sw_stable_q;
    cnt_d       = cnt_q;
    pend_ip_d   = pend_ip_q;
    pend_mac_d  = pend_mac_q;
    ip_d        = ip_q;
    mac_d       = mac_q;
    changes_d   = changes_q;
    case (state_q)
      ST_IDLE: begin
        // first_cfg keeps a lock-deferred initial offer pending
        if (!cfg_lock_i && (first_cfg_q || (sw_sync != sw_stable_q))) begin
          state_d = ST_DEBOUNCE;
          cand_d  = sw_sync;
          cnt_d   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (cfg_lock_i) begin
          state_d = ST_IDLE;
        end else if ((sw_sync == sw_stable_q) && !first_cfg_q) begin
          state_d = ST_IDLE;
        end else if (sw_sync != cand_q) begin
          cand_d = sw_sync;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_UPDATE;
          pend_ip_d  = FPGA_IP_BASE + IP_W'(cand_q);
          pend_mac_d = FPGA_MAC_BASE + MAC_W'(cand_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_UPDATE: begin
        if (cfg_ready_i) begin
          ip_d        = pend_ip_q;
          mac_d       = pend_mac_q;
          sw_stable_d = cand_q;
          changes_d   = changes_q + 8'd1;
          first_cfg_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_DEBOUNCE;
      first_cfg_q <= 1'b1;
      cand_q      <= '0;
      sw_stable_q <= '0;
      cnt_q       <= '0;
      pend_ip_q   <= FPGA_IP_BASE;
      pend_mac_q  <= FPGA_MAC_BASE;
      ip_q        <= FPGA_IP_BASE;
      mac_q       <= FPGA_MAC_BASE;
      changes_q   <= '0;
    end else begin
      state_q     <= state_d;
      first_cfg_q <= first_cfg_d;
      cand_q      <= cand_d;
      sw_stable_q <= sw_stable_d;
      cnt_q       <= cnt_d;
      pend_ip_q   <= pend_ip_d;
      pend_mac_q  <= pend_mac_d;
      ip_q        <= ip_d;
      mac_q       <= mac_d;
      changes_q   <= changes_d;
    end
  end

  assign cfg_valid_o     = (state_q == ST_UPDATE);
  assign cfg_pend_ip_o   = pend_ip_q;
  assign cfg_pend_mac_o  = pend_mac_q;
  assign fpga_ip_addr_o  = ip_q;
  assign fpga_mac_addr_o = mac_q;
  assign home_chipid_o   = NOC_CHIPID_SIZE'(sw_stable_q);
  assign cfg_changes_o   = changes_q;

endmodule

// File: doc/ethernet_addr_cfg_ctrl.md
Name: ethernet_addr_cfg_ctrl

Overview:
Sequences FPGA network-identity configuration from the board DIP switches. It synchronises and debounces the 4-bit switch input, then presents a new IP/MAC/chip-ID set to the Ethernet core over a valid/ready handshake. It commits the set to its outputs only on acceptance, and a lock input freezes configuration while the core is mid-traffic. It sits between the board pins and the Ethernet UDP/NoC bridge.

Parameters:
FPGA_IP_BASE, {8'd192,8'd168,8'd42,8'd240}, IPv4 address for switches = 0
FPGA_MAC_BASE, 48'h080028_030405, MAC address for switches = 0
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required (>=1)
NOC_CHIPID_SIZE, from noc_parameter.vh, chip-ID width (>=4)

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
switches_i  in  4  raw DIP switches, asynchronous to clk_i
cfg_lock_i  in  1  1 = do not start or continue a config change
cfg_ready_i  in  1  Ethernet core accepts pending config
cfg_valid_o  out  1  pending config offered
cfg_pend_ip_o  out  32  pending IP (valid only while cfg_valid_o = 1)
cfg_pend_mac_o  out  48  pending MAC
fpga_ip_addr_o  out  32  committed IP
fpga_mac_addr_o  out  48  committed MAC
home_chipid_o  out  NOC_CHIPID_SIZE  committed chip ID, zero-extended switches
cfg_changes_o  out  8  count of accepted configs, wraps 255 -> 0

Behaviour:
- Reset values: cfg_valid_o = 0; committed IP = FPGA_IP_BASE; committed MAC = FPGA_MAC_BASE; home_chipid_o = 0; cfg_changes_o = 0; pend outputs = base values; state = DEBOUNCE with first_cfg = 1, cand = 0, cnt = 0.
- Synchroniser: 2 flops, reset to 0; sw_sync is the second stage.
- Arithmetic: IP = FPGA_IP_BASE + zero-extended switches, mod 2^32, with full carry across octets. MAC uses the same rule mod 2^48.
- States:
  - IDLE: if sw_sync != sw_stable and !cfg_lock_i, go to DEBOUNCE with cand = sw_sync and cnt = 0.
  - DEBOUNCE:
    - Priority 1: if cfg_lock_i, go to IDLE and clear first_cfg only on commit.
    - Priority 2: if sw_sync == sw_stable and !first_cfg, go to IDLE (glitch returned to the committed value).
    - Priority 3: if sw_sync != cand, set cand = sw_sync and cnt = 0.
    - Priority 4: if cnt == DEBOUNCE_CYCLES-1, go to UPDATE and latch pend from cand.
    - Otherwise cnt++.
    - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - UPDATE: cfg_valid_o = 1 and pend outputs are constant. Switch changes and cfg_lock_i are ignored, so valid never drops without a handshake. On cfg_valid_o & cfg_ready_i in the same cycle, at that edge:
    - committed outputs = pend
    - sw_stable = cand
    - cfg_changes_o++
    - first_cfg = 0
    - go to IDLE, with valid low the next cycle.
- After reset, one config is always offered, even for switches = 0, so the core receives its initial identity. A lock asserted during the initial debounce defers it: IDLE with first_cfg = 1 re-enters DEBOUNCE as soon as lock drops.
- Latency: a stable pin change reaches cfg_valid_o = 1 in DEBOUNCE_CYCLES+3 cycles (+1 for synchroniser phase).
- cfg_ready_i high while not in UPDATE has no effect.
- Committed outputs change only on the handshake edge; they never show intermediate values.
- Reset asserted mid-operation: immediate return to reset values, pending config dropped.
- Single always_ff for state/counters plus combinational next-state; no latches.

Decomposition:
- Package ethernet_cfg_pkg: state encoding localparams (IDLE, DEBOUNCE, UPDATE), IP_W = 32, MAC_W = 48, SW_W = 4.
- NOC_CHIPID_SIZE stays in noc_parameter.vh.
- One sub-module: ethernet_switch_sync (2-flop synchroniser, parameterised width, async active-low reset), reusable for other board inputs.

Test Plan:
- Reset, switches = 4'h0, DEBOUNCE_CYCLES = 8, ready = 1:
  - valid rises at the expected cycle for one cycle, pend_ip = C0A82AF0.
  - After the handshake: chipid = 0, cfg_changes = 1.
- Switches 0 -> 4'h5 held, ready low for 10 cycles after valid, then high:
  - valid held 11 cycles with pend_ip = C0A82AF5 and pend_mac = 080028030 40A.
  - Committed outputs unchanged until the ready edge, then IP ..F5, chipid 5, cfg_changes = 2.
- Bounce 0 -> 3 -> 0 within 5 cycles, then stable at 0:
  - no valid, cfg_changes unchanged.
- Bounce 3 -> 7 at cnt = 5, then stable 7:
  - counter restarts; valid appears 8 cycles after the last edge with chipid pend 7.
- FPGA_IP_BASE = 192.168.42.255, switches = 1:
  - IP = 192.168.43.0 (carry crosses octet).
- cfg_lock_i high with switches changing 0 -> 9:
  - no valid while locked. Lock drop -> valid after the debounce.
- Lock raised during UPDATE:
  - valid stays high until the handshake.
- Reset pulse during UPDATE:
  - valid low immediately, committed outputs back to base values.
